// File: rtl/arb_pkg.sv
// Shared constants, FSM state type and the rotating priority search used by
// rr_tenure_arbiter. The tenure timers are built only when ARB_TENURE_EN is defined.
package arb_pkg;

  localparam int         NPORTS_DEF    = 5;
  localparam logic [2:0] HEAD_ID_DEF   = 3'b001;
  localparam int         DEF_LIMIT_DEF = 16;
  localparam int         MAX_PORTS     = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } pick_t;

  // First set bit of req at or after start, wrapping modulo n (start < n <= MAX_PORTS).
  function automatic pick_t rr_pick(input logic [MAX_PORTS-1:0] req,
                                    input int unsigned         start,
                                    input int unsigned         n);
    pick_t      res;
    logic [4:0] k;
    res = '0;
    for (int unsigned i = 0; i < MAX_PORTS; i++) begin
      if (i < n) begin
        k = 5'(start) + 5'(i);
        if (k >= 5'(n)) k = k - 5'(n);
        if (!res.found && req[k[3:0]]) begin
          res.found = 1'b1;
          res.idx   = k[3:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/tenure_timer.sv
// Per-port tenure limiter: holds the limit captured from the latest header
// flit and counts consecutive granted cycles; expired marks the last allowed
// cycle of the current tenure.
module tenure_timer #(
  parameter int               ID_W      = 3,
  parameter int               LEN_W     = 12,
  parameter logic [ID_W-1:0]  HEAD_ID   = 3'b001,
  parameter int               DEF_LIMIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ID_W-1:0]  flit_id,
  input  logic [LEN_W-1:0] length,
  input  logic             grant,
  output logic             expired
);

  logic [LEN_W-1:0] lim_reg;
  logic [LEN_W-1:0] cnt_reg;

  // Capture a new limit on every header flit, whether or not the port is granted.
  always_ff @(posedge clk) begin
    if (rst)                     lim_reg <= LEN_W'(DEF_LIMIT);
    else if (flit_id == HEAD_ID) lim_reg <= length;
  end

  // Count granted cycles, saturating; any ungranted cycle restarts the count.
  always_ff @(posedge clk) begin
    if (rst || !grant)     cnt_reg <= '0;
    else if (cnt_reg != '1) cnt_reg <= cnt_reg + 1'b1;
  end

  // One extra bit so cnt+1 cannot wrap; a limit of 0 behaves like 1.
  assign expired = ({1'b0, cnt_reg} + (LEN_W+1)'(1)) >= {1'b0, lim_reg};

endmodule

// File: rtl/rr_tenure_arbiter.sv
// N-port round-robin arbiter with registered one-hot grant and optional
// per-port tenure limits (macro ARB_TENURE_EN). Without the macro a port keeps
// the grant for as long as it requests, and flit_id/length are ignored.
module rr_tenure_arbiter
  import arb_pkg::*;
#(
  parameter int              NPORTS    = NPORTS_DEF,
  parameter int              ID_W      = 3,
  parameter int              LEN_W     = 12,
  parameter logic [ID_W-1:0] HEAD_ID   = ID_W'(HEAD_ID_DEF),
  parameter int              DEF_LIMIT = DEF_LIMIT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NPORTS-1:0]         req,
  input  logic [NPORTS*ID_W-1:0]    flit_id,
  input  logic [NPORTS*LEN_W-1:0]   length,
  output logic [NPORTS-1:0]         grant,
  output logic                      grant_valid,
  output logic [$clog2(NPORTS)-1:0] grant_idx,
  output logic                      timeout
);

  localparam int              IDX_W = $clog2(NPORTS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NPORTS-1);

  arb_state_t        state_reg, state_next;
  logic [NPORTS-1:0] grant_reg, grant_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [IDX_W-1:0]  ptr_reg, ptr_next;
  logic              timeout_reg, timeout_next;

  logic [NPORTS-1:0] expired;

`ifdef ARB_TENURE_EN
  generate
    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_timer
      tenure_timer #(
        .ID_W      (ID_W),
        .LEN_W     (LEN_W),
        .HEAD_ID   (HEAD_ID),
        .DEF_LIMIT (DEF_LIMIT)
      ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .flit_id (flit_id[gi*ID_W +: ID_W]),
        .length  (length[gi*LEN_W +: LEN_W]),
        .grant   (grant_reg[gi]),
        .expired (expired[gi])
      );
    end
  endgenerate
`else
  logic unused_cfg;
  assign unused_cfg = ^{flit_id, length};
  assign expired    = '0;
`endif

  // Scan start points: one past the pointer when idle, one past the holder otherwise.
  logic [IDX_W-1:0] ptr_inc, idx_inc;
  pick_t            pick_idle, pick_hold;
  logic             hold_legal, req_cur, exp_cur;

  assign ptr_inc    = (ptr_reg == LAST) ? '0 : ptr_reg + 1'b1;
  assign idx_inc    = (idx_reg == LAST) ? '0 : idx_reg + 1'b1;
  assign pick_idle  = rr_pick(MAX_PORTS'(req), 32'(ptr_inc), NPORTS);
  // Masking the holder is the same as scanning p+1 .. p+NPORTS-1.
  assign pick_hold  = rr_pick(MAX_PORTS'(req & ~grant_reg), 32'(idx_inc), NPORTS);
  assign hold_legal = (idx_reg <= LAST) && (grant_reg == (NPORTS'(1) << idx_reg));
  assign req_cur    = hold_legal && req[idx_reg];
  assign exp_cur    = hold_legal && expired[idx_reg];

  // State register: grant, holder index, rotation pointer and timeout pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      grant_reg   <= '0;
      idx_reg     <= '0;
      ptr_reg     <= LAST;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      idx_reg     <= idx_next;
      ptr_reg     <= ptr_next;
      timeout_reg <= timeout_next;
    end
  end

  // Next-state: hold while requesting and not expired, else hand over by rotation.
  always_comb begin
    state_next   = state_reg;
    grant_next   = grant_reg;
    idx_next     = idx_reg;
    ptr_next     = ptr_reg;
    timeout_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (grant_reg != '0) begin
          grant_next = '0;
          idx_next   = '0;
        end else if (pick_idle.found) begin
          state_next = ST_HOLD;
          idx_next   = IDX_W'(pick_idle.idx);
          ptr_next   = IDX_W'(pick_idle.idx);
          grant_next = NPORTS'(1) << pick_idle.idx;
        end
      end
      ST_HOLD: begin
        if (!hold_legal) begin
          state_next = ST_IDLE;
          grant_next = '0;
          idx_next   = '0;
        end else if (!(req_cur && !exp_cur)) begin
          timeout_next = exp_cur && req_cur;
          if (pick_hold.found) begin
            idx_next   = IDX_W'(pick_hold.idx);
            ptr_next   = IDX_W'(pick_hold.idx);
            grant_next = NPORTS'(1) << pick_hold.idx;
          end else begin
            state_next = ST_IDLE;
            grant_next = '0;
            idx_next   = '0;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        grant_next = '0;
        idx_next   = '0;
      end
    endcase
  end

  assign grant       = grant_reg;
  assign grant_valid = |grant_reg;
  assign grant_idx   = idx_reg;
  assign timeout     = timeout_reg;

endmodule

// File: tb/tb_rr_tenure_arbiter.sv
// Directed bench for rr_tenure_arbiter (NPORTS=5). Tenure-specific steps are
// compiled in when ARB_TENURE_EN is defined; otherwise hold-while-requesting
// steps are checked instead.
module tb_rr_tenure_arbiter;

  localparam int NP  = 5;
  localparam int IDW = 3;
  localparam int LW  = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP-1:0]    req;
  logic [NP*IDW-1:0] flit_id;
  logic [NP*LW-1:0] length;
  logic [NP-1:0]    grant;
  logic             grant_valid;
  logic [2:0]       grant_idx;
  logic             timeout;

  int total = 0;
  int bad   = 0;

  rr_tenure_arbiter #(.NPORTS(NP), .ID_W(IDW), .LEN_W(LW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .flit_id     (flit_id),
    .length      (length),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare all outputs against an expected one-hot grant and timeout.
  task automatic expect_out(input string tag, input logic [NP-1:0] g, input logic to);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < NP; i++) if (g[i]) idx = 3'(i);
    check({tag, ".grant"},   32'(grant),       32'(g));
    check({tag, ".valid"},   32'(grant_valid), 32'(|g));
    check({tag, ".idx"},     32'(grant_idx),   32'(idx));
    check({tag, ".timeout"}, 32'(timeout),     32'(to));
  endtask

  task automatic header(input int p, input logic [LW-1:0] len);
    flit_id[p*IDW +: IDW] = 3'b001;
    length[p*LW +: LW]    = len;
  endtask

  int cur;

  initial begin
    rst = 1'b1; req = '0; flit_id = '0; length = '0;
    repeat (3) step();
    expect_out("reset", 5'b00000, 1'b0);
    rst = 1'b0;

    // Idle with no requests.
    for (int i = 0; i < 10; i++) begin
      step();
      expect_out("idle", 5'b00000, 1'b0);
    end

    // Holder drops while port 3 requests: direct handover, no bubble.
    req = 5'b00010; step(); expect_out("p1_grant", 5'b00010, 1'b0);
    req = 5'b01000; step(); expect_out("p1_to_p3", 5'b01000, 1'b0);

`ifdef ARB_TENURE_EN
    // All ports requesting, default limit 16: rotate 4,0,1,2,3,4.
    req = 5'b00000; step(); expect_out("rot_idle", 5'b00000, 1'b0);
    req = 5'b11111; step(); cur = 4; expect_out("rot_first", 5'b10000, 1'b0);
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 15; c++) begin
        step();
        expect_out("rot_hold", NP'(1) << cur, 1'b0);
      end
      step();
      cur = (cur + 1) % NP;
      expect_out("rot_next", NP'(1) << cur, 1'b1);
    end

    // Port 2 alone with length 3: 3 held, 1 idle with timeout, re-grant.
    req = 5'b00000; step(); expect_out("p2_idle", 5'b00000, 1'b0);
    header(2, 12'd3); req = 5'b00100;
    step(); expect_out("p2_c1", 5'b00100, 1'b0);
    flit_id = '0;
    step(); expect_out("p2_c2", 5'b00100, 1'b0);
    step(); expect_out("p2_c3", 5'b00100, 1'b0);
    step(); expect_out("p2_gap", 5'b00000, 1'b1);
    step(); expect_out("p2_r1", 5'b00100, 1'b0);
    step(); expect_out("p2_r2", 5'b00100, 1'b0);
    step(); expect_out("p2_r3", 5'b00100, 1'b0);
    step(); expect_out("p2_gap2", 5'b00000, 1'b1);

    // Port 4 with length 0: single-cycle tenures.
    req = 5'b00000; step(); expect_out("p4_idle", 5'b00000, 1'b0);
    header(4, 12'd0); req = 5'b10000;
    step(); expect_out("p4_t1", 5'b10000, 1'b0);
    flit_id = '0;
    step(); expect_out("p4_gap1", 5'b00000, 1'b1);
    step(); expect_out("p4_t2", 5'b10000, 1'b0);
    step(); expect_out("p4_gap2", 5'b00000, 1'b1);

    // Header lowers port 1's limit below its count mid-tenure.
    req = 5'b00010;
    step(); expect_out("hdr_c1", 5'b00010, 1'b0);
    step(); expect_out("hdr_c2", 5'b00010, 1'b0);
    header(1, 12'd1);
    step(); expect_out("hdr_c3", 5'b00010, 1'b0);
    flit_id = '0;
    step(); expect_out("hdr_exp", 5'b00000, 1'b1);
`else
    // All ports requesting; rotate by dropping the holder for one edge.
    req = 5'b00000; step(); expect_out("rot_idle", 5'b00000, 1'b0);
    req = 5'b11111; step(); cur = 4; expect_out("rot_first", 5'b10000, 1'b0);
    for (int r = 0; r < 5; r++) begin
      req = 5'b11111 & ~(NP'(1) << cur);
      step();
      cur = (cur + 1) % NP;
      expect_out("rot_next", NP'(1) << cur, 1'b0);
      req = 5'b11111;
      step();
      expect_out("rot_hold", NP'(1) << cur, 1'b0);
    end

    // Port 0 holds 100 cycles against port 1; headers have no effect.
    req = 5'b00000; step(); expect_out("hold_idle", 5'b00000, 1'b0);
    header(0, 12'd1); req = 5'b00011;
    for (int c = 0; c < 100; c++) begin
      step();
      expect_out("hold100", 5'b00001, 1'b0);
    end
    flit_id = '0;
`endif

    // Reset in the middle of port 0's tenure.
    req = 5'b00000; step(); expect_out("rst_idle", 5'b00000, 1'b0);
    req = 5'b00001;
    step(); expect_out("rst_g1", 5'b00001, 1'b0);
    step(); expect_out("rst_g2", 5'b00001, 1'b0);
    rst = 1'b1;
    step(); expect_out("rst_mid", 5'b00000, 1'b0);
    rst = 1'b0; req = 5'b11111;
    step(); expect_out("rst_after", 5'b00001, 1'b0);
    step(); expect_out("rst_after2", 5'b00001, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
